// File: rtl/dap_master.sv
// ============================================================================
// dap_master : byte-wide DAP bus initiator (address + 16-bit word bursts)
// Rev 1.0
// ============================================================================
`default_nettype none

module dap_master #(
  parameter int STROBE_CYC = 6,
  parameter int GAP_CYC    = 6,
  parameter int SETUP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        dap_ce_n,
  output logic        dap_we_n,
  output logic        dap_re_n,
  output logic [7:0]  dap_dout,
  output logic        dap_oe,
  input  logic [7:0]  dap_din,
  input  logic        dap_rdy
);

  localparam logic [7:0] SU_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] LOW_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CE_SU, S_SETUP, S_LOW, S_GAP, S_WAIT_WR, S_CE_HD, S_DONE
  } state_t;

  typedef enum logic [1:0] {P_ADDR, P_WR, P_RD} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  words_q, words_d;
  logic [23:0] addr_q, addr_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        ce_n_q, ce_n_d;
  logic        we_n_q, we_n_d;
  logic        re_n_q, re_n_d;
  logic        oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic        rdy_meta_q, rdy_sync_q;
  logic        last_word;
  logic        strobe_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= P_ADDR;
      byte_q     <= 2'd0;
      cnt_q      <= 8'd0;
      words_q    <= 9'd0;
      addr_q     <= 24'd0;
      is_wr_q    <= 1'b0;
      wdata_q    <= 16'd0;
      rd_lo_q    <= 8'd0;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      re_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= 8'd0;
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      is_wr_q    <= is_wr_d;
      wdata_q    <= wdata_d;
      rd_lo_q    <= rd_lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      re_n_q     <= re_n_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      rdy_meta_q <= dap_rdy;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    addr_d     = addr_q;
    is_wr_d    = is_wr_q;
    wdata_d    = wdata_q;
    rd_lo_d    = rd_lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    dout_d     = dout_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    last_word  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          is_wr_d = cmd_wr;
          words_d = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
          cnt_d   = 8'd0;
          phase_d = P_ADDR;
          byte_d  = 2'd0;
          state_d = S_CE_SU;
        end
      end
      S_CE_SU: begin
        if (cnt_q == SU_LAST) begin
          cnt_d   = 8'd0;
          dout_d  = addr_q[7:0];
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SETUP: begin
        // Data strobes wait here, counter frozen, until the slave reports ready
        if (cnt_q != SU_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else if (phase_q == P_ADDR || rdy_sync_q) begin
          cnt_d   = 8'd0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == LOW_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_GAP;
          if (phase_q == P_RD) begin
            if (byte_q == 2'd0) begin
              rd_lo_d = dap_din;
            end else begin
              rd_data_d  = {dap_din, rd_lo_q};
              rd_valid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (phase_q == P_ADDR && byte_q != 2'd2) begin
            byte_d  = byte_q + 2'd1;
            dout_d  = (byte_q == 2'd0) ? addr_q[15:8] : addr_q[23:16];
            state_d = S_SETUP;
          end else if (phase_q != P_ADDR && byte_q == 2'd0) begin
            byte_d  = 2'd1;
            dout_d  = (phase_q == P_WR) ? wdata_q[15:8] : dout_q;
            state_d = S_SETUP;
          end else begin
            // End of address phase or of a complete word
            byte_d = 2'd0;
            if (phase_q != P_ADDR) begin
              words_d   = words_q - 9'd1;
              last_word = (words_q == 9'd1);
            end
            if (last_word) begin
              state_d = S_CE_HD;
            end else if (is_wr_q) begin
              phase_d = P_WR;
              state_d = S_WAIT_WR;
            end else begin
              phase_d = P_RD;
              state_d = S_SETUP;
            end
          end
        end
      end
      S_WAIT_WR: begin
        wr_ready = wr_valid;
        if (wr_valid) begin
          wdata_d = wr_data;
          dout_d  = wr_data[7:0];
          cnt_d   = 8'd0;
          state_d = S_SETUP;
        end
      end
      S_CE_HD: begin
        if (cnt_q == SU_LAST) begin
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          dout_d  = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus pins are registered from the next-state decode so they never glitch
    strobe_low = (state_d == S_LOW);
    ce_n_d     = (state_d == S_IDLE) || (state_d == S_DONE);
    we_n_d     = !(strobe_low && phase_d != P_RD);
    re_n_d     = !(strobe_low && phase_d == P_RD);
    oe_d       = (phase_d != P_RD) &&
                 (state_d inside {S_SETUP, S_LOW, S_GAP, S_WAIT_WR});
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign dap_ce_n = ce_n_q;
  assign dap_we_n = we_n_q;
  assign dap_re_n = re_n_q;
  assign dap_oe   = oe_q;
  assign dap_dout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_dap_master.sv
// ============================================================================
// tb_dap_master : randomized bench for dap_master with a bus-level slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dap_master;

  localparam int STROBE = 6;
  localparam int GAP    = 6;
  localparam int SU     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [23:0] cmd_addr = 24'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [15:0] wr_data = 16'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        dap_ce_n, dap_we_n, dap_re_n, dap_oe;
  logic [7:0]  dap_dout;
  logic [7:0]  dap_din = 8'd0;
  logic        dap_rdy = 1'b1;

  dap_master #(.STROBE_CYC(STROBE), .GAP_CYC(GAP), .SETUP_CYC(SU)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .dap_ce_n(dap_ce_n), .dap_we_n(dap_we_n), .dap_re_n(dap_re_n),
    .dap_dout(dap_dout), .dap_oe(dap_oe), .dap_din(dap_din), .dap_rdy(dap_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave memory content seen by reads: a salted identity map
  logic [15:0] salt = 16'd0;
  function automatic logic [15:0] rd_model(input logic [23:0] a);
    return a[15:0] ^ salt;
  endfunction

  // Bus monitor + slave model, evaluated mid-cycle
  int we_pulses = 0, re_pulses = 0, we_falls = 0, re_falls = 0;
  int we_low = 0, re_low = 0, bad_width = 0, viol = 0, oe_viol = 0;
  int ce_high = 0, wrrdy_cnt = 0, rd_cnt = 0, done_cnt = 0, sw_cnt = 0, cyc = 0;
  int byte_idx = 0;
  bit rsel = 1'b0;
  bit p_we = 1'b1, p_re = 1'b1, p_ce = 1'b1;
  logic [23:0] s_addr = 24'd0, last_addr = 24'd0;
  logic [7:0]  s_lo = 8'd0;
  logic [15:0] rdw;
  logic [7:0]  we_log [0:1023];
  logic [15:0] rd_log [0:4095];
  logic [23:0] sw_addr [0:4095];
  logic [15:0] sw_data [0:4095];
  logic [15:0] tx_words [0:255];

  initial forever begin
    @(negedge clk);
    cyc++;
    if ((!dap_we_n && !dap_re_n) || (dap_ce_n && (!dap_we_n || !dap_re_n))) viol++;
    if (!dap_re_n && dap_oe) oe_viol++;
    if (dap_ce_n) ce_high++;
    if (p_ce && !dap_ce_n) begin
      byte_idx = 0;
      rsel = 1'b0;
    end
    if (!dap_we_n) begin
      if (p_we) begin we_falls++; we_low = 0; end
      we_low++;
    end else if (!p_we) begin
      if (we_low != STROBE) bad_width++;
      we_log[we_pulses % 1024] = dap_dout;
      we_pulses++;
      if (byte_idx < 3) begin
        s_addr[8*byte_idx +: 8] = dap_dout;
        if (byte_idx == 2) last_addr = s_addr;
      end else if (((byte_idx - 3) % 2) == 0) begin
        s_lo = dap_dout;
      end else begin
        sw_addr[sw_cnt % 4096] = s_addr;
        sw_data[sw_cnt % 4096] = {dap_dout, s_lo};
        sw_cnt++;
        s_addr = s_addr + 24'd1;
      end
      byte_idx++;
    end
    if (!dap_re_n) begin
      if (p_re) begin re_falls++; re_low = 0; end
      re_low++;
    end else if (!p_re) begin
      if (re_low != STROBE) bad_width++;
      re_pulses++;
      if (rsel) s_addr = s_addr + 24'd1;
      rsel = !rsel;
    end
    rdw = rd_model(s_addr);
    dap_din = (!dap_re_n && !dap_ce_n) ? (rsel ? rdw[15:8] : rdw[7:0]) : 8'h00;
    if (wr_ready) wrrdy_cnt++;
    if (rd_valid) begin
      rd_log[rd_cnt % 4096] = rd_data;
      rd_cnt++;
    end
    if (done) done_cnt++;
    p_we = dap_we_n;
    p_re = dap_re_n;
    p_ce = dap_ce_n;
  end

  task automatic issue(input bit wr, input logic [23:0] a, input logic [7:0] len);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input bit wr, input logic [23:0] a, input int len,
                           input int stall_word, input int stall_cyc,
                           input int rdy_hold, input bit rand_timing);
    int n, budget, b_we, b_re, b_rf, b_wrr, b_rd, b_done, b_bw, b_v, b_oev, b_sw;
    bit finished, timed_out;
    n = (len == 0) ? 256 : len;
    budget = 400 + n * 80 + stall_cyc + rdy_hold;
    b_we = we_pulses; b_re = re_pulses; b_rf = re_falls; b_wrr = wrrdy_cnt;
    b_rd = rd_cnt; b_done = done_cnt; b_bw = bad_width; b_v = viol;
    b_oev = oe_viol; b_sw = sw_cnt;
    finished = 1'b0; timed_out = 1'b0;
    @(negedge clk);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    issue(wr, a, 8'(len));
    fork
      begin : g_wait_done
        int i;
        i = 0;
        while (done_cnt == b_done && i < budget) begin
          @(negedge clk);
          i++;
        end
        timed_out = (done_cnt == b_done);
        finished  = 1'b1;
      end
      begin : g_feed
        if (wr) begin
          for (int w = 0; w < n && !finished; w++) begin
            bit hs;
            if (w == stall_word && stall_cyc > 0) begin
              int f0, c0;
              f0 = we_falls; c0 = ce_high;
              repeat (stall_cyc) @(posedge clk);
              #1;
              check_eq("stall_we_falls", we_falls - f0, 2);
              check_eq("stall_ce_high", ce_high - c0, 0);
            end else if (rand_timing) begin
              repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            wr_data  = tx_words[w];
            wr_valid = 1'b1;
            hs = 1'b0;
            while (!hs && !finished) begin
              @(negedge clk);
              hs = wr_ready;
            end
            @(posedge clk); #1;
            wr_valid = 1'b0;
            wr_data  = 16'($urandom);
          end
        end
      end
      begin : g_rdy
        if (rdy_hold > 0) begin
          int t0;
          while (we_pulses < b_we + 3 && !finished) @(negedge clk);
          t0 = cyc;
          dap_rdy = 1'b0;
          repeat (rdy_hold) @(negedge clk);
          dap_rdy = 1'b1;
          while (re_falls == b_rf && !finished) @(negedge clk);
          check_eq("rdy_holdoff_ge", ((cyc - t0) >= rdy_hold), 1);
        end else if (rand_timing) begin
          while (!finished) begin
            @(posedge clk); #1;
            dap_rdy = ($urandom_range(0, 5) != 0);
          end
        end
        dap_rdy = 1'b1;
      end
    join
    check_eq("done_timeout", timed_out, 0);
    repeat (2) @(negedge clk);
    check_eq("ready_after_done", {cmd_ready, dap_ce_n}, 2'b11);
    check_eq("done_pulses", done_cnt - b_done, 1);
    check_eq("we_pulses", we_pulses - b_we, wr ? 3 + 2 * n : 3);
    check_eq("re_pulses", re_pulses - b_re, wr ? 0 : 2 * n);
    check_eq("wr_ready_pulses", wrrdy_cnt - b_wrr, wr ? n : 0);
    check_eq("rd_valid_pulses", rd_cnt - b_rd, wr ? 0 : n);
    check_eq("strobe_width", bad_width - b_bw, 0);
    check_eq("strobe_overlap", viol - b_v, 0);
    check_eq("oe_during_read", oe_viol - b_oev, 0);
    check_eq("slave_addr", last_addr, a);
    if (wr) begin
      check_eq("slave_writes", sw_cnt - b_sw, n);
      for (int i = 0; i < n; i++) begin
        check_eq("wr_addr", sw_addr[(b_sw + i) % 4096], a + 24'(i));
        check_eq("wr_word", sw_data[(b_sw + i) % 4096], tx_words[i]);
      end
    end else begin
      for (int i = 0; i < n; i++)
        check_eq("rd_word", rd_log[(b_rd + i) % 4096], rd_model(a + 24'(i)));
    end
  endtask

  logic [7:0] exp7 [0:6];

  initial begin
    int b_we, b_re, b_rd, b_done, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ce_we_re_oe", {dap_ce_n, dap_we_n, dap_re_n, dap_oe}, 4'b1110);
    check_eq("reset_ready_pulses", {cmd_ready, wr_ready, rd_valid, done}, 4'b1000);
    check_eq("reset_dout", dap_dout, 0);
    check_eq("reset_rd_data", rd_data, 0);
    rst = 1'b0;

    // Write burst with known byte sequence
    tx_words[0] = 16'hBEEF; tx_words[1] = 16'h0102;
    exp7[0] = 8'h56; exp7[1] = 8'h34; exp7[2] = 8'h12; exp7[3] = 8'hEF;
    exp7[4] = 8'hBE; exp7[5] = 8'h02; exp7[6] = 8'h01;
    b_we = we_pulses;
    run_burst(1'b1, 24'h123456, 2, -1, 0, 0, 1'b0);
    for (int i = 0; i < 7; i++)
      check_eq("we_byte", we_log[(b_we + i) % 1024], exp7[i]);

    // Read burst, slave returns its address as data
    salt = 16'h0000;
    run_burst(1'b0, 24'h000010, 3, -1, 0, 0, 1'b0);

    // Write with a 50-cycle data stall before the second word
    for (int i = 0; i < 3; i++) tx_words[i] = 16'($urandom);
    run_burst(1'b1, 24'(($urandom)), 3, 1, 50, 0, 1'b0);

    // Slave not ready for 20 cycles ahead of the first read strobe
    salt = 16'($urandom);
    run_burst(1'b0, 24'h00ABCD, 2, -1, 0, 20, 1'b0);

    // Length 0 means 256 words
    for (int i = 0; i < 256; i++) tx_words[i] = 16'($urandom);
    run_burst(1'b1, 24'hFFFF00, 0, -1, 0, 0, 1'b0);

    // Reset in the middle of a read
    salt = 16'h5A5A;
    b_re = re_pulses; b_rd = rd_cnt; b_done = done_cnt;
    issue(1'b0, 24'h000200, 8'd4);
    k = 0;
    while (re_pulses == b_re && k < 500) begin @(negedge clk); k++; end
    check_eq("mid_read_first_strobe", re_pulses - b_re, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_bus", {dap_ce_n, dap_we_n, dap_re_n, dap_oe}, 4'b1110);
    check_eq("mid_rst_pulses", {rd_valid, done, cmd_ready}, 3'b001);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("mid_rst_no_rd_valid", rd_cnt - b_rd, 0);
    check_eq("mid_rst_no_done", done_cnt - b_done, 0);
    run_burst(1'b0, 24'h000300, 2, -1, 0, 0, 1'b0);

    // Randomized mix of bursts with jittered data and ready
    for (int t = 0; t < 10; t++) begin
      int len;
      bit wr;
      len  = $urandom_range(1, 6);
      wr   = 1'($urandom_range(0, 1));
      salt = 16'($urandom);
      for (int i = 0; i < len; i++) tx_words[i] = 16'($urandom);
      run_burst(wr, 24'($urandom), len, -1, 0, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
